// File: rtl/multi_tc_gen.sv
// Multi-channel timer/counter: one free-running prescaler shared by N channels.
// Each channel selects a prescaler tap as its tick and runs as free-run, one-shot or PWM.
module multi_tc_gen #(
  parameter int N    = 3,
  parameter int W    = 8,
  parameter int PSW  = 32,
  parameter int TAPW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      ch_en,
  input  logic [2*N-1:0]    ch_mode,
  input  logic [TAPW*N-1:0] ch_tap,
  input  logic [W*N-1:0]    ch_top,
  input  logic [W*N-1:0]    ch_cmp,
  input  logic [N-1:0]      ch_start,
  output logic [W*N-1:0]    cnt_out,
  output logic [N-1:0]      pwm_out,
  output logic [N-1:0]      wrap_pulse,
  output logic [N-1:0]      done
);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_FREE    = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_PWM     = 2'b11
  } mode_e;

  localparam int PIW = (PSW > 1) ? $clog2(PSW) : 1;
  localparam logic [PSW-1:0] PS_ONE  = PSW'(1);
  localparam logic [W-1:0]   CNT_ONE = W'(1);
  localparam logic [W-1:0]   CNT_ZERO = W'(0);

  // Out-of-range tap indices select the prescaler MSB.
  function automatic logic [PIW-1:0] clamp_tap(input logic [TAPW-1:0] tap);
    logic [PIW-1:0] idx;
    if (32'(tap) >= 32'(PSW)) begin
      idx = PIW'(PSW - 1);
    end else begin
      idx = PIW'(tap);
    end
    return idx;
  endfunction

  logic [PSW-1:0] ps_r;
  logic [N-1:0]   prev_r;
  logic [W-1:0]   cnt_r [N];
  logic [N-1:0]   run_r;
  logic [N-1:0]   done_r;
  logic [N-1:0]   wrap_r;

  mode_e          mode_s    [N];
  logic [W-1:0]   top_s     [N];
  logic [W-1:0]   cmp_s     [N];
  logic [N-1:0]   tap_bit_s;
  logic [N-1:0]   tick_s;
  logic [W-1:0]   cnt_nx_s  [N];
  logic [N-1:0]   run_nx_s;
  logic [N-1:0]   done_nx_s;
  logic [N-1:0]   wrap_nx_s;

  // Per-channel field extraction and rising-edge tick detection on the selected tap.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      mode_s[i]    = mode_e'(ch_mode[2*i +: 2]);
      top_s[i]     = ch_top[W*i +: W];
      cmp_s[i]     = ch_cmp[W*i +: W];
      tap_bit_s[i] = ps_r[clamp_tap(ch_tap[TAPW*i +: TAPW])];
      tick_s[i]    = tap_bit_s[i] & ~prev_r[i];
    end
  end

  // Next-state for each channel: OFF > start > enabled tick > hold.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      cnt_nx_s[i]  = cnt_r[i];
      run_nx_s[i]  = run_r[i];
      done_nx_s[i] = done_r[i];
      wrap_nx_s[i] = 1'b0;
      if (mode_s[i] == MODE_OFF) begin
        cnt_nx_s[i]  = CNT_ZERO;
        run_nx_s[i]  = 1'b0;
        done_nx_s[i] = 1'b0;
      end else if (ch_start[i]) begin
        cnt_nx_s[i]  = CNT_ZERO;
        done_nx_s[i] = 1'b0;
        if (mode_s[i] == MODE_ONESHOT) begin
          run_nx_s[i] = 1'b1;
        end else begin
          run_nx_s[i] = run_r[i];
        end
      end else if (ch_en[i] && tick_s[i]) begin
        case (mode_s[i])
          MODE_FREE, MODE_PWM: begin
            // >= so that lowering top below the current count wraps on the next tick.
            if (cnt_r[i] >= top_s[i]) begin
              cnt_nx_s[i]  = CNT_ZERO;
              wrap_nx_s[i] = 1'b1;
            end else begin
              cnt_nx_s[i] = cnt_r[i] + CNT_ONE;
            end
          end
          MODE_ONESHOT: begin
            if (!run_r[i]) begin
              cnt_nx_s[i] = cnt_r[i];
            end else if (cnt_r[i] >= top_s[i]) begin
              run_nx_s[i]  = 1'b0;
              done_nx_s[i] = 1'b1;
            end else begin
              cnt_nx_s[i] = cnt_r[i] + CNT_ONE;
            end
          end
          default: begin
            cnt_nx_s[i] = cnt_r[i];
          end
        endcase
      end else begin
        cnt_nx_s[i] = cnt_r[i];
      end
    end
  end

  // Prescaler, tap history and channel state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ps_r   <= '0;
      prev_r <= '0;
      run_r  <= '0;
      done_r <= '0;
      wrap_r <= '0;
      for (int i = 0; i < N; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
    end else begin
      ps_r   <= ps_r + PS_ONE;
      prev_r <= tap_bit_s;
      run_r  <= run_nx_s;
      done_r <= done_nx_s;
      wrap_r <= wrap_nx_s;
      for (int i = 0; i < N; i++) begin
        cnt_r[i] <= cnt_nx_s[i];
      end
    end
  end

  // Output buses; PWM is decoded straight from the count register.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      cnt_out[W*i +: W] = cnt_r[i];
      pwm_out[i]        = (mode_s[i] == MODE_PWM) && (cnt_r[i] < cmp_s[i]);
    end
    wrap_pulse = wrap_r;
    done       = done_r;
  end

endmodule

// File: tb/tb_multi_tc_gen.sv
// Self-checking bench for multi_tc_gen: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model driven by cycle-count arithmetic.
module tb_multi_tc_gen;
  localparam int N = 3, W = 8, PSW = 32, TAPW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [N-1:0]      ch_en, ch_start;
  logic [2*N-1:0]    ch_mode;
  logic [TAPW*N-1:0] ch_tap;
  logic [W*N-1:0]    ch_top, ch_cmp;
  logic [W*N-1:0]    cnt_out;
  logic [N-1:0]      pwm_out, wrap_pulse, done;

  multi_tc_gen #(.N(N), .W(W), .PSW(PSW), .TAPW(TAPW)) dut (
    .clk(clk), .rst(rst), .ch_en(ch_en), .ch_mode(ch_mode), .ch_tap(ch_tap),
    .ch_top(ch_top), .ch_cmp(ch_cmp), .ch_start(ch_start), .cnt_out(cnt_out),
    .pwm_out(pwm_out), .wrap_pulse(wrap_pulse), .done(done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: cycles since reset, plus per-channel count/running/done/wrap.
  longint m_ps;
  int     m_cnt  [N];
  bit     m_run  [N];
  bit     m_done [N];
  bit     m_wrap [N];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int cnt_of(input int i);
    return int'(cnt_out[W*i +: W]);
  endfunction

  // One clock edge of the reference behaviour, using the inputs currently applied.
  task automatic model_step();
    int md, t, top;
    longint per;
    bit tk;
    if (rst) begin
      m_ps = 0;
      for (int i = 0; i < N; i++) begin
        m_cnt[i] = 0; m_run[i] = 0; m_done[i] = 0; m_wrap[i] = 0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        md  = int'(ch_mode[2*i +: 2]);
        t   = int'(ch_tap[TAPW*i +: TAPW]);
        top = int'(ch_top[W*i +: W]);
        if (t >= PSW) t = PSW - 1;
        per = longint'(1) << (t + 1);
        tk  = ((m_ps % per) == (per / 2));
        m_wrap[i] = 0;
        if (md == 0) begin
          m_cnt[i] = 0; m_run[i] = 0; m_done[i] = 0;
        end else if (ch_start[i]) begin
          m_cnt[i] = 0; m_done[i] = 0;
          if (md == 2) m_run[i] = 1;
        end else if (ch_en[i] && tk) begin
          if (md == 2) begin
            if (m_run[i]) begin
              if (m_cnt[i] >= top) begin m_run[i] = 0; m_done[i] = 1; end
              else m_cnt[i]++;
            end
          end else if (m_cnt[i] >= top) begin
            m_cnt[i] = 0; m_wrap[i] = 1;
          end else begin
            m_cnt[i]++;
          end
        end
      end
      m_ps = (m_ps + 1) & 64'hFFFF_FFFF;
    end
  endtask

  task automatic check_all();
    int cmpv;
    bit pexp;
    for (int i = 0; i < N; i++) begin
      cmpv = int'(ch_cmp[W*i +: W]);
      pexp = (ch_mode[2*i +: 2] == 2'b11) && (m_cnt[i] < cmpv);
      check_val($sformatf("cnt%0d", i),  64'(cnt_of(i)),     64'(m_cnt[i]));
      check_val($sformatf("wrap%0d", i), 64'(wrap_pulse[i]), 64'(m_wrap[i]));
      check_val($sformatf("done%0d", i), 64'(done[i]),       64'(m_done[i]));
      check_val($sformatf("pwm%0d", i),  64'(pwm_out[i]),    64'(pexp));
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  // Taps only change while the channel is held OFF for one edge.
  task automatic config_ch(input int i, input logic [1:0] md, input int tp, input int top, input int cmp);
    ch_mode[2*i +: 2]      = 2'b00;
    ch_tap[TAPW*i +: TAPW] = TAPW'(tp);
    ch_top[W*i +: W]       = W'(top);
    ch_cmp[W*i +: W]       = W'(cmp);
    cycle();
    ch_mode[2*i +: 2] = md;
  endtask

  task automatic pulse_start(input int i);
    ch_start[i] = 1'b1;
    cycle();
    ch_start[i] = 1'b0;
  endtask

  task automatic wait_cnt(input int i, input int val, input int budget, input string tag);
    int k = 0;
    while (cnt_of(i) != val && k < budget) begin cycle(); k++; end
    check_val({tag, "_reached"}, 64'(cnt_of(i)), 64'(val));
  endtask

  task automatic wait_change(input int i, input int budget, input string tag);
    int k = 0;
    int prev = cnt_of(i);
    while (cnt_of(i) == prev && k < budget) begin cycle(); k++; end
    check_val({tag, "_moved"}, 64'(k < budget), 64'(1));
  endtask

  int acc, mx;
  bit retap [N];

  initial begin
    rst = 1'b1; ch_en = '0; ch_start = '0; ch_mode = '0; ch_tap = '0; ch_top = '0; ch_cmp = '0;
    m_ps = 0;
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 0; m_run[i] = 0; m_done[i] = 0; m_wrap[i] = 0; retap[i] = 0;
    end
    repeat (3) cycle();
    rst = 1'b0;
    check_val("reset_cnt",  64'(cnt_out),    64'(0));
    check_val("reset_wrap", 64'(wrap_pulse), 64'(0));
    check_val("reset_done", 64'(done),       64'(0));
    check_val("reset_pwm",  64'(pwm_out),    64'(0));

    // Free-run, tap 0, top 3: two wraps per 16 clk, count peaks at 3.
    config_ch(0, 2'b01, 0, 3, 0);
    ch_en[0] = 1'b1;
    acc = 0; mx = 0;
    repeat (16) begin
      cycle();
      acc += int'(wrap_pulse[0]);
      if (cnt_of(0) > mx) mx = cnt_of(0);
    end
    check_val("free_wraps16", 64'(acc), 64'(2));
    check_val("free_max", 64'(mx), 64'(3));

    // Reset while counting.
    wait_cnt(0, 2, 20, "pre_rst");
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check_val("rst_mid_cnt", 64'(cnt_out), 64'(0));
    check_val("rst_mid_done", 64'(done), 64'(0));

    // One-shot, tap 1, top 5.
    config_ch(1, 2'b10, 1, 5, 0);
    ch_en[1] = 1'b1;
    pulse_start(1);
    acc = 0;
    repeat (40) begin cycle(); acc += int'(wrap_pulse[1]); end
    check_val("os_done", 64'(done[1]), 64'(1));
    check_val("os_hold", 64'(cnt_of(1)), 64'(5));
    check_val("os_nowrap", 64'(acc), 64'(0));
    pulse_start(1);
    check_val("os_rearm_done", 64'(done[1]), 64'(0));
    check_val("os_rearm_cnt", 64'(cnt_of(1)), 64'(0));

    // PWM, tap 0, top 9: duty across one 20-clk period for several compare values.
    config_ch(2, 2'b11, 0, 9, 3);
    ch_en[2] = 1'b1;
    pulse_start(2);
    repeat (4) cycle();
    acc = 0;
    repeat (20) begin cycle(); acc += int'(pwm_out[2]); end
    check_val("pwm_cmp3", 64'(acc), 64'(6));
    ch_cmp[W*2 +: W] = 8'd0;
    acc = 0;
    repeat (20) begin cycle(); acc += int'(pwm_out[2]); end
    check_val("pwm_cmp0", 64'(acc), 64'(0));
    ch_cmp[W*2 +: W] = 8'd12;
    acc = 0;
    repeat (20) begin cycle(); acc += int'(pwm_out[2]); end
    check_val("pwm_cmp12", 64'(acc), 64'(20));

    // Pause at 2, then resume at 3.
    config_ch(0, 2'b01, 0, 7, 0);
    pulse_start(0);
    wait_cnt(0, 2, 20, "pause");
    ch_en[0] = 1'b0;
    repeat (10) cycle();
    check_val("pause_hold", 64'(cnt_of(0)), 64'(2));
    ch_en[0] = 1'b1;
    wait_change(0, 10, "resume");
    check_val("resume_val", 64'(cnt_of(0)), 64'(3));

    // Start on a tick edge (tap 0 ticks when the cycle count is odd).
    if (m_ps % 2 == 0) cycle();
    pulse_start(0);
    check_val("start_vs_tick", 64'(cnt_of(0)), 64'(0));

    // Lower top from 7 to 1 at count 5.
    wait_cnt(0, 5, 30, "top_low");
    ch_top[W*0 +: W] = 8'd1;
    wait_change(0, 10, "top_low");
    check_val("top_low_cnt", 64'(cnt_of(0)), 64'(0));
    check_val("top_low_wrap", 64'(wrap_pulse[0]), 64'(1));

    // Tap 31: no tick inside the run.
    config_ch(0, 2'b01, 31, 255, 0);
    pulse_start(0);
    repeat (100) cycle();
    check_val("tap31_idle", 64'(cnt_of(0)), 64'(0));

    // OFF mid-count clears on the next edge.
    config_ch(1, 2'b01, 0, 200, 0);
    pulse_start(1);
    repeat (20) cycle();
    ch_mode[3:2] = 2'b00;
    cycle();
    check_val("off_clear", 64'(cnt_of(1)), 64'(0));

    // Randomized traffic, model-checked every cycle.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (retap[i]) begin
          ch_mode[2*i +: 2] = 2'($urandom_range(1, 3));
          retap[i] = 1'b0;
        end else if ($urandom_range(0, 99) == 0) begin
          ch_mode[2*i +: 2] = 2'b00;
          ch_tap[TAPW*i +: TAPW] = ($urandom_range(0, 7) == 0) ? 5'd31 : TAPW'($urandom_range(0, 2));
          retap[i] = 1'b1;
        end else if ($urandom_range(0, 99) == 0) begin
          ch_mode[2*i +: 2] = 2'($urandom_range(0, 3));
        end
        ch_en[i]    = ($urandom_range(0, 9) != 0);
        ch_start[i] = ($urandom_range(0, 49) == 0);
        if ($urandom_range(0, 49) == 0) ch_top[W*i +: W] = W'($urandom_range(0, 12));
        if ($urandom_range(0, 19) == 0) ch_cmp[W*i +: W] = W'($urandom_range(0, 14));
      end
      rst = ($urandom_range(0, 999) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
